prefetch_line_buffer: RTL
=========================

# prefetch_line_buffer

Parametrised direct-mapped L2 prefetch buffer, next generation of the single-word prefetch tag/data store. It holds 2^IDXW lines of 2^WPLW words each, answers CPU read lookups with one-cycle latency, fills missed lines from backing memory through a request/acknowledge burst, keeps resident lines coherent with snooped CPU writes (byte-masked merge), and supports whole-buffer flush by index sweep. Sits between the CPU read path and the DRAM/ROM fill port.

## Interface
- AW, 26, word-address width (byte address bits [AW+1:2])
- IDXW, 7, line index width; 2^IDXW lines
- WPLW, 2, log2 words per line
- TAGW: derived, AW-IDXW-WPLW; not overridable
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- RDA  in  AW  lookup word address
- RDREQ  in  1  lookup strobe
- RDD  out  32  lookup data; valid when Match=1
- Match  out  1  registered hit for lookup of previous cycle
- WRA  in  AW  snooped write word address
- WRD  in  32  snooped write data
- WR  in  1  snooped write strobe
- WRM  in  4  byte enables, WRM[3] = WRD[31:24]
- CLR  in  1  flush request (one-cycle pulse suffices)
- FillReq  out  1  fill word request
- FillA  out  AW  fill word address
- FillAck  in  1  fill word accepted; FillD valid this cycle
- FillD  in  32  fill data
- Busy  out  1  high in FILL or FLUSH

## Operation
- Address split: tag = A[AW-1:IDXW+WPLW], index = A[IDXW+WPLW-1:WPLW], word = A[WPLW-1:0].
- Per line: valid bit + tag. Data RAM 2^(IDXW+WPLW) x 32, read-before-write.
- States: FLUSH, IDLE, FILL.
- FLUSH: counter 0..2^IDXW-1 clears one valid bit per cycle; leaves to IDLE after clearing last index. RST or CLR in any state enters FLUSH with counter=0 (CLR in FLUSH restarts sweep). CLR in FILL aborts the fill.
- IDLE: RDREQ lookup hit -> Match=1, RDD=word. Miss -> Match=0, latch line base (word bits zero), state FILL.
- FILL: FillReq=1, FillA=base+counter. Each FillAck cycle writes FillD to RAM and increments counter (WPLW bits). Ack of last word writes tag, sets valid (unless poisoned), returns to IDLE. Lookups during FILL are serviced; misses start no new fill. The line under fill reads as miss until completion.
- Snoop: WR with tag match on valid resident line merges WRD bytes per WRM into RAM. WR to the line under fill sets poison flag; poisoned fill completes handshake but leaves line invalid. Snoop ignored in FLUSH.
- Fill overwrites index: valid cleared at FILL entry.

## Timing
- Reset values: Match=0, RDD=0, FillReq=0, FillA=0, Busy=1 (FLUSH); buffer usable 2^IDXW+1 cycles after RST falls.
- Lookup latency 1: RDREQ at edge n -> Match/RDD at n+1. Match=0 on cycles without RDREQ of previous cycle.
- Miss at edge n -> FillReq=1 at n+1. FillReq held until last ack; drops the cycle after. Line hits for lookups issued the cycle after last ack.
- Abort: FillReq drops the cycle after CLR; late FillAck ignored; memory side must tolerate withdrawn request.
- Read and snoop to same word same cycle: RDD returns pre-write data.
- FillAck and snoop to same word same cycle: fill wins, line poisoned.
- FillAck outside FILL ignored.

## Test plan
- Reset, 130 cycles idle, lookup 0x0000040 -> Busy low after 129 cycles, Match=0, FillReq next cycle with FillA=0x0000040.
- Fill 4 words 0xA0..0xA3 with ack every other cycle -> FillA steps 0x40..0x43; lookups 0x41 next cycle Match=1 RDD=0xA1.
- Snoop WR WRA=0x42 WRD=0xFFFFFFFF WRM=4'b0011 on resident line -> lookup RDD=0x0000FFFF merged over 0xA2 (0x0000FFFF).
- Snoop to line during fill -> fill completes, subsequent lookup Match=0, new fill started.
- CLR mid-fill after 2 acks -> FillReq low next cycle, Busy high 128 cycles, all prior hits now miss.
- Tag conflict: fill 0x40 then lookup 0x2040 (same index) -> miss, refill, then 0x40 misses.

Source files
------------

// File: rtl/prefetch_line_buffer.sv
// Direct-mapped prefetch line buffer. Answers CPU lookups with one-cycle latency,
// refills missed lines by a request/ack burst, byte-merges snooped writes and flushes by index sweep.
module prefetch_line_buffer #(
  parameter int AW   = 26,
  parameter int IDXW = 7,
  parameter int WPLW = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] RDA,
  input  logic          RDREQ,
  output logic [31:0]   RDD,
  output logic          Match,
  input  logic [AW-1:0] WRA,
  input  logic [31:0]   WRD,
  input  logic          WR,
  input  logic [3:0]    WRM,
  input  logic          CLR,
  output logic          FillReq,
  output logic [AW-1:0] FillA,
  input  logic          FillAck,
  input  logic [31:0]   FillD,
  output logic          Busy
);

  localparam int TAGW = AW - IDXW - WPLW;
  localparam int NL   = 1 << IDXW;
  localparam int NW   = 1 << (IDXW + WPLW);
  localparam int LW   = AW - WPLW;

  typedef enum logic [1:0] {
    S_FLUSH,
    S_IDLE,
    S_FILL
  } state_e;

  state_e              state_q, state_d;
  logic [IDXW-1:0]     flcnt_q, flcnt_d;
  logic [WPLW-1:0]     fcnt_q, fcnt_d;
  logic [LW-1:0]       base_q, base_d;
  logic                poison_q, poison_d;
  logic                match_q;
  logic [31:0]         rdd_q;

  logic [NL-1:0]       valid_q;
  logic [TAGW-1:0]     tag_mem [NL];
  logic [31:0]         data_mem [NW];

  logic [TAGW-1:0]     rd_tag, wr_tag;
  logic [IDXW-1:0]     rd_idx, wr_idx, fill_idx;
  logic [IDXW+WPLW-1:0] rd_addr, wr_addr, fill_addr;
  logic [LW-1:0]       rd_line, wr_line;
  logic                rd_hit, snoop_hit;

  logic                valid_clr, valid_set, tag_we, fill_we;
  logic [IDXW-1:0]     valid_clr_idx;

  assign rd_tag    = RDA[AW-1:IDXW+WPLW];
  assign rd_idx    = RDA[IDXW+WPLW-1:WPLW];
  assign rd_addr   = RDA[IDXW+WPLW-1:0];
  assign rd_line   = RDA[AW-1:WPLW];
  assign wr_tag    = WRA[AW-1:IDXW+WPLW];
  assign wr_idx    = WRA[IDXW+WPLW-1:WPLW];
  assign wr_addr   = WRA[IDXW+WPLW-1:0];
  assign wr_line   = WRA[AW-1:WPLW];
  assign fill_idx  = base_q[IDXW-1:0];
  assign fill_addr = {fill_idx, fcnt_q};

  // The line under fill has its valid bit cleared at fill entry, so it reads as a miss
  // without a separate comparison against the fill base.
  assign rd_hit    = (state_q != S_FLUSH) && valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign snoop_hit = WR && (state_q != S_FLUSH) && valid_q[wr_idx] && (tag_mem[wr_idx] == wr_tag);

  always_comb begin
    state_d       = state_q;
    flcnt_d       = flcnt_q;
    fcnt_d        = fcnt_q;
    base_d        = base_q;
    poison_d      = poison_q;
    valid_clr     = 1'b0;
    valid_clr_idx = '0;
    valid_set     = 1'b0;
    tag_we        = 1'b0;
    fill_we       = 1'b0;

    case (state_q)
      S_FLUSH: begin
        valid_clr     = 1'b1;
        valid_clr_idx = flcnt_q;
        flcnt_d       = flcnt_q + 1'b1;
        if (flcnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (RDREQ && !rd_hit) begin
          state_d       = S_FILL;
          base_d        = rd_line;
          fcnt_d        = '0;
          poison_d      = WR && (wr_line == rd_line);
          valid_clr     = 1'b1;
          valid_clr_idx = rd_idx;
        end
      end
      S_FILL: begin
        if (WR && (wr_line == base_q)) poison_d = 1'b1;
        if (FillAck) begin
          fill_we = 1'b1;
          fcnt_d  = fcnt_q + 1'b1;
          if (fcnt_q == '1) begin
            tag_we    = 1'b1;
            valid_set = !poison_d;
            state_d   = S_IDLE;
          end
        end
      end
      default: state_d = S_FLUSH;
    endcase

    // Flush request overrides everything, including an ack arriving in the same cycle.
    if (CLR) begin
      state_d   = S_FLUSH;
      flcnt_d   = '0;
      fill_we   = 1'b0;
      tag_we    = 1'b0;
      valid_set = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_FLUSH;
      flcnt_q  <= '0;
      fcnt_q   <= '0;
      base_q   <= '0;
      poison_q <= 1'b0;
      match_q  <= 1'b0;
      rdd_q    <= '0;
    end else begin
      state_q  <= state_d;
      flcnt_q  <= flcnt_d;
      fcnt_q   <= fcnt_d;
      base_q   <= base_d;
      poison_q <= poison_d;
      match_q  <= RDREQ && rd_hit;
      if (RDREQ) rdd_q <= data_mem[rd_addr];
    end
  end

  // Storage arrays: no reset, validity is established by the flush sweep.
  always_ff @(posedge CLK) begin
    if (valid_clr) valid_q[valid_clr_idx] <= 1'b0;
    if (valid_set) valid_q[fill_idx] <= 1'b1;
    if (tag_we) tag_mem[fill_idx] <= base_q[LW-1:IDXW];
    if (snoop_hit) begin
      if (WRM[0]) data_mem[wr_addr][7:0]   <= WRD[7:0];
      if (WRM[1]) data_mem[wr_addr][15:8]  <= WRD[15:8];
      if (WRM[2]) data_mem[wr_addr][23:16] <= WRD[23:16];
      if (WRM[3]) data_mem[wr_addr][31:24] <= WRD[31:24];
    end
    if (fill_we) data_mem[fill_addr] <= FillD;
  end

  assign Match   = match_q;
  assign RDD     = rdd_q;
  assign FillReq = (state_q == S_FILL);
  assign FillA   = {base_q, fcnt_q};
  assign Busy    = (state_q != S_IDLE);

endmodule
